// File: rtl/irrigation_actuator_seq_pkg.sv
// Shared state and mode codes and default timing constants for the
// irrigation actuator sequencer.
package irrigation_actuator_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_OPEN  = 3'd1,
      ST_RUN   = 3'd2,
      ST_STOP  = 3'd3,
      ST_ERROR = 3'd4
   } stateT;

   typedef enum logic {
      MODE_DRIP = 1'b0,
      MODE_SPRK = 1'b1
   } modeT;

   localparam int DEF_CNT_W        = 8;
   localparam int DEF_DEB_TICKS    = 4;
   localparam int DEF_SETTLE_TICKS = 8;
   localparam int DEF_MIN_ON_TICKS = 32;
   localparam int DEF_DRAIN_TICKS  = 8;

endpackage

// File: rtl/irrigation_actuator_seq_if.sv
// Request/sensor inputs and actuator outputs of the sequencer; the controller
// side is the master, the sequencer is the slave.
interface irrigation_actuator_seq_if;
   logic       tick;
   logic       Vs;
   logic       Bs;
   logic       H;
   logic       M;
   logic       L;
   logic       err_clr;
   logic       valve_drip;
   logic       valve_sprk;
   logic       pump;
   logic       fault;
   logic [2:0] state;

   modport master (
      output tick, Vs, Bs, H, M, L, err_clr,
      input  valve_drip, valve_sprk, pump, fault, state
   );

   modport slave (
      input  tick, Vs, Bs, H, M, L, err_clr,
      output valve_drip, valve_sprk, pump, fault, state
   );
endinterface

// File: rtl/irrigation_actuator_seq_tick_debounce.sv
// Tick-based debouncer: the filtered value follows the raw input only after
// DEB_TICKS consecutive ticks of disagreement.
module tick_debounce #(
   parameter int CNT_W     = 8,
   parameter int DEB_TICKS = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic raw,
   output logic filt
);
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt  <= '0;
         filt <= 1'b0;
      end else if (raw == filt) begin
         cnt <= '0;
      end else if (tick) begin
         // flip on the tick that completes the run of disagreement
         if (int'(cnt) + 1 >= DEB_TICKS) begin
            filt <= raw;
            cnt  <= '0;
         end else if (cnt != '1) begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end
endmodule

// File: rtl/irrigation_actuator_seq.sv
// Actuator sequencer: debounced requests drive valve-then-pump ordering with
// settle, minimum run, drain, dry-run cut-off and a latched sensor fault.
module irrigation_actuator_seq
   import irrigation_actuator_seq_pkg::*;
#(
   parameter int CNT_W        = DEF_CNT_W,
   parameter int DEB_TICKS    = DEF_DEB_TICKS,
   parameter int SETTLE_TICKS = DEF_SETTLE_TICKS,
   parameter int MIN_ON_TICKS = DEF_MIN_ON_TICKS,
   parameter int DRAIN_TICKS  = DEF_DRAIN_TICKS
) (
   input logic                      clk,
   input logic                      rst,
   irrigation_actuator_seq_if.slave bus
);
   logic vsF, bsF, faultF, rawFault;

   // inconsistent level pattern: a higher sensor wet while a lower one is dry
   assign rawFault = (bus.H & ~bus.M) | (bus.M & ~bus.L);

   tick_debounce #(.CNT_W(CNT_W), .DEB_TICKS(DEB_TICKS)) uDebVs (
      .clk(clk), .rst(rst), .tick(bus.tick), .raw(bus.Vs), .filt(vsF)
   );
   tick_debounce #(.CNT_W(CNT_W), .DEB_TICKS(DEB_TICKS)) uDebBs (
      .clk(clk), .rst(rst), .tick(bus.tick), .raw(bus.Bs), .filt(bsF)
   );
   tick_debounce #(.CNT_W(CNT_W), .DEB_TICKS(DEB_TICKS)) uDebFault (
      .clk(clk), .rst(rst), .tick(bus.tick), .raw(rawFault), .filt(faultF)
   );

   stateT            st, stNext;
   modeT             mode, modeNext;
   logic [CNT_W-1:0] timer, timerInc;
   logic             actReq, othReq, valveOn;

   assign timerInc = (bus.tick && timer != '1) ? timer + CNT_W'(1) : timer;
   assign actReq   = (mode == MODE_DRIP) ? vsF : bsF;
   assign othReq   = (mode == MODE_DRIP) ? bsF : vsF;

   always_comb begin
      stNext   = st;
      modeNext = mode;
      case (st)
         ST_IDLE: begin
            if ((vsF | bsF) & bus.L) begin
               stNext   = ST_OPEN;
               modeNext = vsF ? MODE_DRIP : MODE_SPRK;
            end
         end
         ST_OPEN: begin
            if (!bus.L)                                  stNext = ST_STOP;
            else if (int'(timerInc) >= SETTLE_TICKS)     stNext = ST_RUN;
         end
         ST_RUN: begin
            if (!bus.L)                                  stNext = ST_STOP;
            else if ((!actReq || othReq) && int'(timerInc) >= MIN_ON_TICKS)
                                                         stNext = ST_STOP;
         end
         ST_STOP: begin
            if (int'(timerInc) >= DRAIN_TICKS)           stNext = ST_IDLE;
         end
         ST_ERROR: begin
            if (bus.err_clr && !faultF)                  stNext = ST_IDLE;
         end
         default:                                        stNext = ST_IDLE;
      endcase
      if (faultF) stNext = ST_ERROR;
   end

   assign valveOn = (stNext == ST_OPEN) || (stNext == ST_RUN) || (stNext == ST_STOP);

   // outputs decoded from the next state so they change in step with the state code
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st             <= ST_IDLE;
         mode           <= MODE_DRIP;
         timer          <= '0;
         bus.valve_drip <= 1'b0;
         bus.valve_sprk <= 1'b0;
         bus.pump       <= 1'b0;
         bus.fault      <= 1'b0;
         bus.state      <= ST_IDLE;
      end else begin
         st             <= stNext;
         mode           <= modeNext;
         timer          <= (stNext != st) ? '0 : timerInc;
         bus.valve_drip <= valveOn && (modeNext == MODE_DRIP);
         bus.valve_sprk <= valveOn && (modeNext == MODE_SPRK);
         bus.pump       <= (stNext == ST_RUN);
         bus.fault      <= (stNext == ST_ERROR);
         bus.state      <= stNext;
      end
   end
endmodule

// File: tb/tb_irrigation_actuator_seq.sv
// Scoreboard bench: stimulus pushes reference-model expectations, a monitor
// pops and compares the actuator outputs every cycle.
module tb_irrigation_actuator_seq;
   localparam int DEB = 2, SETTLE = 2, MIN_ON = 4, DRAIN = 2, CMAX = 255;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   irrigation_actuator_seq_if ifc ();

   irrigation_actuator_seq #(
      .CNT_W(8), .DEB_TICKS(DEB), .SETTLE_TICKS(SETTLE),
      .MIN_ON_TICKS(MIN_ON), .DRAIN_TICKS(DRAIN)
   ) dut (
      .clk(clk), .rst(rst), .bus(ifc)
   );

   int total = 0;
   int bad   = 0;
   logic [6:0] expQ[$];

   // stimulus values
   logic sTick, sVs, sBs, sH, sM, sL, sEc;

   // reference model: state codes 0..4 idle/open/run/stop/error, mode 0 drip 1 sprinkler
   int mSt, mTimer;
   bit mMode;
   int dCnt[3];
   bit dF[3];

   function automatic logic [6:0] expOut();
      bit act;
      act = (mSt >= 1 && mSt <= 3);
      return {act && !mMode, act && mMode, mSt == 2, mSt == 4, 3'(mSt)};
   endfunction

   task automatic modelReset();
      mSt = 0; mMode = 0; mTimer = 0;
      for (int i = 0; i < 3; i++) begin dCnt[i] = 0; dF[i] = 0; end
      expQ.delete();
      expQ.push_back(7'b0);
   endtask

   task automatic modelEdge();
      bit raw[3];
      int nx, tN;
      bit nm, req, oth;
      if (rst) begin modelReset(); return; end
      raw[0] = ifc.Vs; raw[1] = ifc.Bs;
      raw[2] = (ifc.H && !ifc.M) || (ifc.M && !ifc.L);
      tN = ifc.tick ? ((mTimer < CMAX) ? mTimer + 1 : CMAX) : mTimer;
      req = mMode ? dF[1] : dF[0];
      oth = mMode ? dF[0] : dF[1];
      nx = mSt; nm = mMode;
      if (dF[2]) nx = 4;
      else if ((mSt == 1 || mSt == 2) && !ifc.L) nx = 3;
      else if (mSt == 0) begin
         if ((dF[0] || dF[1]) && ifc.L) begin nx = 1; nm = dF[0] ? 0 : 1; end
      end
      else if (mSt == 1) begin if (tN >= SETTLE) nx = 2; end
      else if (mSt == 2) begin if ((!req || oth) && tN >= MIN_ON) nx = 3; end
      else if (mSt == 3) begin if (tN >= DRAIN) nx = 0; end
      else if (mSt == 4) begin if (ifc.err_clr && !dF[2]) nx = 0; end
      mTimer = (nx != mSt) ? 0 : tN;
      mSt = nx; mMode = nm;
      for (int i = 0; i < 3; i++) begin
         if (raw[i] == dF[i]) dCnt[i] = 0;
         else if (ifc.tick) begin
            dCnt[i]++;
            if (dCnt[i] >= DEB) begin dF[i] = raw[i]; dCnt[i] = 0; end
         end
      end
      expQ.push_back(expOut());
   endtask

   task automatic step(int n);
      for (int k = 0; k < n; k++) begin
         ifc.tick = sTick; ifc.Vs = sVs; ifc.Bs = sBs;
         ifc.H = sH; ifc.M = sM; ifc.L = sL; ifc.err_clr = sEc;
         @(posedge clk);
         modelEdge();
         #1;
      end
   endtask

   // reset asserted between edges, held over one edge, released between edges
   task automatic asyncRst();
      #2;
      rst = 1'b1;
      modelReset();
      #1;
      step(1);
      #2;
      rst = 1'b0;
   endtask

   // monitor
   initial begin
      logic [6:0] want, got;
      forever begin
         @(negedge clk or posedge rst);
         #1;
         if (expQ.size() != 0) begin
            want = expQ.pop_front();
            got  = {ifc.valve_drip, ifc.valve_sprk, ifc.pump, ifc.fault, ifc.state};
            total++;
            if (got !== want) begin
               bad++;
               $display("FAIL outputs @%0t: got drip/sprk/pump/fault/state=%b required=%b",
                        $time, got, want);
            end
            total++;
            if ((got[6] & got[5]) !== 1'b0) begin
               bad++;
               $display("FAIL valve_exclusive @%0t: drip=%b sprk=%b required not both",
                        $time, got[6], got[5]);
            end
         end
      end
   end

   initial begin
      int lvl;
      sTick = 1; sVs = 0; sBs = 0; sH = 0; sM = 1; sL = 1; sEc = 0;
      ifc.tick = 1; ifc.Vs = 0; ifc.Bs = 0; ifc.H = 0; ifc.M = 1; ifc.L = 1; ifc.err_clr = 0;
      #1;
      rst = 1'b1;
      modelReset();
      step(2);
      #2;
      rst = 1'b0;
      step(3);
      // drip cycle
      sVs = 1; step(12); sVs = 0; step(12);
      // glitch on Bs
      sBs = 1; step(1); sBs = 0; step(6);
      // mode swap drip -> sprinkler
      sVs = 1; step(8); sVs = 0; sBs = 1; step(24); sBs = 0; step(14);
      // dry-run at first run tick
      sVs = 1; step(6); sM = 0; sL = 0; step(6); sM = 1; sL = 1; sVs = 0; step(10);
      // sensor fault, early acknowledge, then fix and acknowledge
      sVs = 1; step(7); sH = 1; sM = 0; step(4);
      sEc = 1; step(2); sEc = 0; sH = 0; sM = 1; step(3);
      sEc = 1; step(1); sEc = 0; sVs = 0; step(14);
      // async reset mid-run
      sVs = 1; step(7); asyncRst(); step(3); sVs = 0; step(10);
      // randomized phase
      for (int c = 0; c < 1500; c++) begin
         sTick = ($urandom_range(99) < 75);
         if ($urandom_range(99) < 6) sVs = ~sVs;
         if ($urandom_range(99) < 6) sBs = ~sBs;
         if ($urandom_range(99) < 4) begin
            lvl = $urandom_range(9);
            case (lvl)
               5:       begin sH = 1; sM = 1; sL = 1; end
               6:       begin sH = 0; sM = 0; sL = 1; end
               7:       begin sH = 0; sM = 0; sL = 0; end
               8:       begin sH = 1; sM = 0; sL = 1; end
               9:       begin sH = 1; sM = 1; sL = 0; end
               default: begin sH = 0; sM = 1; sL = 1; end
            endcase
         end
         sEc = ($urandom_range(99) < 10);
         if ($urandom_range(999) < 3) asyncRst();
         else step(1);
      end
      step(2);
      #10;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
